// File: rtl/csc_pkg.sv
// Shared types and helpers for the CSC stream encoder.
package csc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENCODE = 2'd1,
      TERM   = 2'd2,
      CLEAR  = 2'd3
   } state_e;

   function automatic logic [31:0] all_ones(input int unsigned width);
      return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
   endfunction

   function automatic logic [31:0] zero_col_marker(input int unsigned width);
      return all_ones(width);
   endfunction

   function automatic logic [31:0] dummy_count(input int unsigned width);
      return all_ones(width);
   endfunction

endpackage

// File: rtl/csc_sync_fifo.sv
// First-word-fall-through synchronous FIFO; reports its free-slot count.
module csc_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   free_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             push;
   logic             pop;

   always_comb begin
      pop     = rd_en_i && (count_q != '0);
      push    = wr_en_i && (count_q != CNT_W'(DEPTH));
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Storage is cleared on reset so the head word reads 0 when empty after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign valid_o   = (count_q != '0);
   assign free_o    = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/csc_stream_encoder.sv
// Column-major dense-to-CSC encoder with back-pressured address and data output streams.
module csc_stream_encoder
   import csc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned COUNT_WIDTH = 4,
   parameter int unsigned ADDR_WIDTH  = 7,
   parameter int unsigned DIM_WIDTH   = 5,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ZERO_MODE   = 0
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              data_in_valid,
   output logic                              data_in_ready,
   input  logic [DATA_WIDTH-1:0]             data_in,
   input  logic [DIM_WIDTH-1:0]              matrix_height,
   input  logic [DIM_WIDTH-1:0]              matrix_width,
   input  logic                              clear_req,
   output logic                              address_out_valid,
   input  logic                              address_out_ready,
   output logic [ADDR_WIDTH-1:0]             address_out,
   output logic                              data_out_valid,
   input  logic                              data_out_ready,
   output logic [DATA_WIDTH+COUNT_WIDTH-1:0] data_out,
   output logic                              one_vector_done,
   output logic                              addr_overflow
);

   localparam int unsigned DW    = DATA_WIDTH + COUNT_WIDTH;
   localparam int unsigned FW    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned MAX_H = dummy_count(COUNT_WIDTH);
   localparam logic [ADDR_WIDTH-1:0]  ADDR_ONES  = ADDR_WIDTH'(zero_col_marker(ADDR_WIDTH));
   localparam logic [ADDR_WIDTH-1:0]  NNZ_MAX    = ADDR_ONES - ADDR_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONES   = COUNT_WIDTH'(dummy_count(COUNT_WIDTH));
   localparam logic [DW-1:0]          DUMMY_WORD = {DATA_WIDTH'(1), CNT_ONES};

   state_e                 state_q;
   logic [DIM_WIDTH-1:0]   row_q, row_d;
   logic [DIM_WIDTH-1:0]   col_q, col_d;
   logic [DIM_WIDTH-1:0]   h_q, h_d;
   logic [DIM_WIDTH-1:0]   w_q, w_d;
   logic [ADDR_WIDTH-1:0]  nnz_q, nnz_d;
   logic                   col_nz_q, col_nz_d;
   logic                   ovf_q, ovf_d;
   logic                   done_q;

   logic [DIM_WIDTH-1:0]   eff_h, eff_w;
   logic                   dims_ok, has_room, idle_take;
   logic                   accept, nz, col_nz, last_row, last_elem, beat_wr;
   logic [ADDR_WIDTH-1:0]  nnz_inc, nnz_dummy;
   logic                   a_wr, d_wr;
   logic [ADDR_WIDTH-1:0]  a_wdata;
   logic [DW-1:0]          d_wdata;
   logic [FW-1:0]          a_free, d_free;

   // Handshake, counter update and FIFO write generation for one element per cycle.
   always_comb begin
      eff_h     = (state_q == IDLE) ? matrix_height : h_q;
      eff_w     = (state_q == IDLE) ? matrix_width  : w_q;
      dims_ok   = (eff_h != '0) && (eff_w != '0) && (32'(eff_h) <= MAX_H);
      has_room  = (d_free >= FW'(2)) && (a_free != '0);
      idle_take = (state_q == IDLE) && !clear_req && dims_ok;
      data_in_ready = !reset && has_room && (idle_take || (state_q == ENCODE));
      accept    = data_in_valid && data_in_ready;
      nz        = (data_in != '0);
      col_nz    = col_nz_q || nz;
      last_row  = (row_q == eff_h - DIM_WIDTH'(1));
      last_elem = last_row && (col_q == eff_w - DIM_WIDTH'(1));
      beat_wr   = ((state_q == TERM) || (state_q == CLEAR)) && (d_free != '0) && (a_free != '0);

      row_d     = row_q;
      col_d     = col_q;
      h_d       = h_q;
      w_d       = w_q;
      nnz_d     = nnz_q;
      col_nz_d  = col_nz_q;
      ovf_d     = ovf_q;
      nnz_inc   = nnz_q;
      nnz_dummy = nnz_q;
      a_wr      = 1'b0;
      a_wdata   = '0;
      d_wr      = 1'b0;
      d_wdata   = '0;

      if ((state_q == IDLE) && data_in_valid && !clear_req && !dims_ok) begin
         ovf_d = 1'b1;
      end

      if (accept) begin
         if (state_q == IDLE) begin
            h_d = matrix_height;
            w_d = matrix_width;
         end
         if (nz) begin
            d_wr    = 1'b1;
            d_wdata = {data_in, COUNT_WIDTH'(row_q)};
            if (nnz_q >= NNZ_MAX) begin
               ovf_d = 1'b1;
            end else begin
               nnz_inc = nnz_q + ADDR_WIDTH'(1);
            end
         end
         nnz_d    = nnz_inc;
         row_d    = row_q + DIM_WIDTH'(1);
         col_nz_d = col_nz;
         if (last_row) begin
            row_d    = '0;
            col_nz_d = 1'b0;
            col_d    = col_q + DIM_WIDTH'(1);
            a_wr     = 1'b1;
            if (col_nz) begin
               a_wdata = nnz_inc;
            end else if (ZERO_MODE == 0) begin
               a_wdata = ADDR_ONES;
            end else begin
               // Empty column in dummy mode consumes one data slot and one pointer step.
               if (nnz_inc >= NNZ_MAX) begin
                  ovf_d = 1'b1;
               end else begin
                  nnz_dummy = nnz_inc + ADDR_WIDTH'(1);
               end
               d_wr    = 1'b1;
               d_wdata = DUMMY_WORD;
               a_wdata = nnz_dummy;
               nnz_d   = nnz_dummy;
            end
            if (last_elem) begin
               col_d = '0;
               nnz_d = '0;
            end
         end
      end

      if (beat_wr) begin
         a_wr = 1'b1;
         d_wr = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         row_q    <= '0;
         col_q    <= '0;
         h_q      <= '0;
         w_q      <= '0;
         nnz_q    <= '0;
         col_nz_q <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         row_q    <= row_d;
         col_q    <= col_d;
         h_q      <= h_d;
         w_q      <= w_d;
         nnz_q    <= nnz_d;
         col_nz_q <= col_nz_d;
         ovf_q    <= ovf_d;
         // Pointer 0 only ever appears as a terminator or clear beat.
         done_q   <= address_out_valid && address_out_ready && (address_out == '0);
         case (state_q)
            IDLE: begin
               if (clear_req) begin
                  state_q <= CLEAR;
               end else if (accept) begin
                  state_q <= last_elem ? TERM : ENCODE;
               end
            end
            ENCODE: begin
               if (accept && last_elem) begin
                  state_q <= TERM;
               end
            end
            TERM, CLEAR: begin
               if (beat_wr) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign one_vector_done = done_q;
   assign addr_overflow   = ovf_q;

   csc_sync_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_addr_fifo (
      .clock     (clock),
      .reset     (reset),
      .wr_en_i   (a_wr),
      .wr_data_i (a_wdata),
      .rd_en_i   (address_out_ready),
      .rd_data_o (address_out),
      .valid_o   (address_out_valid),
      .free_o    (a_free)
   );

   csc_sync_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_data_fifo (
      .clock     (clock),
      .reset     (reset),
      .wr_en_i   (d_wr),
      .wr_data_i (d_wdata),
      .rd_en_i   (data_out_ready),
      .rd_data_o (data_out),
      .valid_o   (data_out_valid),
      .free_o    (d_free)
   );

endmodule

// File: tb/tb_csc_stream_encoder.sv
// Scoreboard bench: three encoder instances (default, dummy zero-column, 3-bit pointers) share stimulus.
module tb_csc_stream_encoder;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic [7:0]  data_in;
   logic [4:0]  mh, mw;
   logic        aready, dready;
   logic [2:0]  vin, clr, rdy, aval, dval, done, ovf;
   logic [6:0]  a0, a1;
   logic [2:0]  a2;
   logic [11:0] d0, d1, d2;

   int checks = 0, errors = 0, done_cnt = 0, exp_done = 0, acc_cnt = 0;
   logic [8:0]  exp_a[$];
   logic [13:0] exp_d[$];
   logic [8:0]  e_a;
   logic [13:0] e_d;
   logic        send_done;
   int          acc0;

   csc_stream_encoder #(.ZERO_MODE(0)) dut0 (
      .clock(clock), .reset(reset), .data_in_valid(vin[0]), .data_in_ready(rdy[0]), .data_in(data_in),
      .matrix_height(mh), .matrix_width(mw), .clear_req(clr[0]),
      .address_out_valid(aval[0]), .address_out_ready(aready), .address_out(a0),
      .data_out_valid(dval[0]), .data_out_ready(dready), .data_out(d0),
      .one_vector_done(done[0]), .addr_overflow(ovf[0]));

   csc_stream_encoder #(.ZERO_MODE(1)) dut1 (
      .clock(clock), .reset(reset), .data_in_valid(vin[1]), .data_in_ready(rdy[1]), .data_in(data_in),
      .matrix_height(mh), .matrix_width(mw), .clear_req(clr[1]),
      .address_out_valid(aval[1]), .address_out_ready(aready), .address_out(a1),
      .data_out_valid(dval[1]), .data_out_ready(dready), .data_out(d1),
      .one_vector_done(done[1]), .addr_overflow(ovf[1]));

   csc_stream_encoder #(.ADDR_WIDTH(3)) dut2 (
      .clock(clock), .reset(reset), .data_in_valid(vin[2]), .data_in_ready(rdy[2]), .data_in(data_in),
      .matrix_height(mh), .matrix_width(mw), .clear_req(clr[2]),
      .address_out_valid(aval[2]), .address_out_ready(aready), .address_out(a2),
      .data_out_valid(dval[2]), .data_out_ready(dready), .data_out(d2),
      .one_vector_done(done[2]), .addr_overflow(ovf[2]));

   function automatic logic [6:0] aout_of(input int k);
      if (k == 0) return a0;
      if (k == 1) return a1;
      return {4'b0, a2};
   endfunction

   function automatic logic [11:0] dout_of(input int k);
      if (k == 0) return d0;
      if (k == 1) return d1;
      return d2;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic exp_addr(input int k, input int v);
      exp_a.push_back({2'(k), 7'(v)});
   endtask

   task automatic exp_data(input int k, input int val, input int row);
      exp_d.push_back({2'(k), 8'(val), 4'(row)});
   endtask

   task automatic send(input int k, input logic [7:0] v);
      int n;
      n = 0;
      data_in = v;
      vin[k]  = 1'b1;
      @(negedge clock);
      while (!rdy[k] && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) chk("send_timeout", n, 0);
      @(posedge clock);
      #1 vin[k] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_a.size() != 0 || exp_d.size() != 0) && n < 300) begin
         @(posedge clock);
         n++;
      end
      repeat (3) @(posedge clock);
      #1;
      chk("drain_timeout", (n < 300) ? 1 : 0, 1);
      chk("done_count", done_cnt, exp_done);
   endtask

   // Monitor: pops the scoreboard on every accepted output beat.
   always @(negedge clock) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            if (vin[k] && rdy[k]) acc_cnt++;
            if (done[k]) done_cnt++;
            if (aval[k] && aready) begin
               checks++;
               if (exp_a.size() == 0) begin
                  errors++;
                  $display("FAIL addr_extra dut%0d got=%0d", k, aout_of(k));
               end else begin
                  e_a = exp_a.pop_front();
                  if (e_a != {2'(k), aout_of(k)}) begin
                     errors++;
                     $display("FAIL addr_stream dut%0d got=%0d exp dut%0d addr=%0d", k, aout_of(k), e_a[8:7], e_a[6:0]);
                  end
               end
            end
            if (dval[k] && dready) begin
               checks++;
               if (exp_d.size() == 0) begin
                  errors++;
                  $display("FAIL data_extra dut%0d got=%h", k, dout_of(k));
               end else begin
                  e_d = exp_d.pop_front();
                  if (e_d != {2'(k), dout_of(k)}) begin
                     errors++;
                     $display("FAIL data_stream dut%0d got=%h exp dut%0d word=%h", k, dout_of(k), e_d[13:12], e_d[11:0]);
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; vin = '0; clr = '0; data_in = '0; mh = 5'd3; mw = 5'd2;
      aready = 1'b1; dready = 1'b1; send_done = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("ready_in_reset", int'(rdy), 0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("ready_after_reset", int'(rdy), 7);
      chk("avalid_after_reset", int'(aval), 0);
      chk("dvalid_after_reset", int'(dval), 0);
      chk("aout_after_reset", int'(a0), 0);
      chk("dout_after_reset", int'(d0), 0);
      chk("done_after_reset", int'(done), 0);
      chk("ovf_after_reset", int'(ovf), 0);
      @(posedge clock);
      #1;

      // 3x2 matrix, then a 2x3 matrix back-to-back on the default instance
      mh = 5'd3; mw = 5'd2;
      exp_data(0, 5, 1); exp_data(0, -2, 0); exp_data(0, 7, 2); exp_data(0, 0, 0);
      exp_addr(0, 1); exp_addr(0, 3); exp_addr(0, 0);
      exp_done++;
      send(0, 8'd0); send(0, 8'd5); send(0, 8'd0); send(0, -8'sd2); send(0, 8'd0); send(0, 8'd7);
      mh = 5'd2; mw = 5'd3;
      exp_data(0, 1, 0); exp_data(0, 3, 1); exp_data(0, 0, 0);
      exp_addr(0, 1); exp_addr(0, 127); exp_addr(0, 2); exp_addr(0, 0);
      exp_done++;
      send(0, 8'd1); send(0, 8'd0); send(0, 8'd0); send(0, 8'd0); send(0, 8'd0); send(0, 8'd3);
      drain();

      // Same 2x3 matrix with dummy zero-column words
      exp_data(1, 1, 0); exp_data(1, 1, 15); exp_data(1, 3, 1); exp_data(1, 0, 0);
      exp_addr(1, 1); exp_addr(1, 2); exp_addr(1, 3); exp_addr(1, 0);
      exp_done++;
      send(1, 8'd1); send(1, 8'd0); send(1, 8'd0); send(1, 8'd0); send(1, 8'd0); send(1, 8'd3);
      drain();

      // 4x4 all non-zero with data_out_ready held low for 20 cycles
      mh = 5'd4; mw = 5'd4;
      for (int i = 0; i < 16; i++) exp_data(0, i + 1, i % 4);
      for (int c = 0; c < 4; c++) exp_addr(0, (c + 1) * 4);
      exp_addr(0, 0); exp_data(0, 0, 0);
      exp_done++;
      dready = 1'b0;
      acc0 = acc_cnt;
      send_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++) send(0, 8'(i + 1));
            send_done = 1'b1;
         end
      join_none
      repeat (20) @(posedge clock);
      #1;
      chk("bp_accepted", acc_cnt - acc0, 3);
      chk("bp_ready_low", int'(rdy[0]), 0);
      chk("bp_dvalid_held", int'(dval[0]), 1);
      chk("bp_head_word", int'(d0), 12'h010);
      dready = 1'b1;
      for (int n = 0; n < 300 && !send_done; n++) @(posedge clock);
      chk("bp_send_finished", int'(send_done), 1);
      drain();

      // Clear request wins over a simultaneous element
      mh = 5'd3; mw = 5'd2;
      acc0 = acc_cnt;
      clr[0] = 1'b1; vin[0] = 1'b1; data_in = 8'd9;
      @(negedge clock);
      chk("clear_ready_low", int'(rdy[0]), 0);
      @(posedge clock);
      #1 clr[0] = 1'b0; vin[0] = 1'b0;
      exp_addr(0, 0); exp_data(0, 0, 0);
      exp_done++;
      drain();
      chk("clear_no_accept", acc_cnt - acc0, 0);

      // Illegal dimensions
      mh = 5'd0; mw = 5'd2; vin[0] = 1'b1; data_in = 8'd3;
      @(negedge clock);
      chk("h0_ready_low", int'(rdy[0]), 0);
      @(posedge clock);
      #1 vin[0] = 1'b0;
      chk("h0_overflow_flag", int'(ovf[0]), 1);
      mh = 5'd16;
      @(negedge clock);
      chk("h16_ready_low", int'(rdy[0]), 0);
      @(posedge clock);
      #1;

      // 8x1 all non-zero into 3-bit pointers: saturation at 6
      mh = 5'd8; mw = 5'd1;
      for (int i = 0; i < 8; i++) exp_data(2, i + 1, i);
      exp_addr(2, 6); exp_addr(2, 0); exp_data(2, 0, 0);
      exp_done++;
      for (int i = 0; i < 8; i++) begin
         send(2, 8'(i + 1));
         if (i == 5) chk("ovf_after_6th", int'(ovf[2]), 0);
         if (i == 6) chk("ovf_after_7th", int'(ovf[2]), 1);
      end
      drain();

      // Reset in the middle of a matrix discards everything
      aready = 1'b0; dready = 1'b0;
      send(2, 8'd1); send(2, 8'd2);
      chk("mid_dvalid", int'(dval[2]), 1);
      chk("mid_head_word", int'(d2), 12'h010);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_ready_in_reset", int'(rdy), 0);
      @(posedge clock);
      #1;
      chk("mid_dvalid_cleared", int'(dval[2]), 0);
      chk("mid_dout_cleared", int'(d2), 0);
      chk("mid_ovf2_cleared", int'(ovf[2]), 0);
      chk("mid_ovf0_cleared", int'(ovf[0]), 0);
      reset = 1'b0;
      @(negedge clock);
      chk("mid_ready_after", int'(rdy[2]), 1);
      @(posedge clock);
      #1 aready = 1'b1; dready = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      chk("addr_queue_empty", exp_a.size(), 0);
      chk("data_queue_empty", exp_d.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
